// File: rtl/new_task_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// OmpSsManager package
// Shared constants for the OmpSs task manager blocks.
//   ACC_BITS    : width of an accelerator index (at most 4, tid is 4 bits wide)
//   HWR_DEPS_ID : tdest value that routes a new-task message to the hardware
//                 dependence manager instead of the scheduler
// -----------------------------------------------------------------------------
package OmpSsManager;

   localparam int         ACC_BITS    = 4;
   localparam logic [4:0] HWR_DEPS_ID = 5'h1F;

endpackage

// File: rtl/new_task_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin choice. The request vector is rotated so that the
// source after last_grant_i sits at bit 0, the lowest set bit is found, and the
// resulting offset is rotated back into an absolute source index.
// Ports:
//   req_i        : per-source request
//   last_grant_i : index granted most recently (search starts one above it)
//   found_o      : at least one request is pending
//   grant_o      : chosen source index (valid when found_o is 1)
// -----------------------------------------------------------------------------
module rr_picker #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] last_grant_i,
   output logic         found_o,
   output logic [W-1:0] grant_o
);

   logic [2*N-1:0] req_dbl;
   logic [2*N-1:0] req_shift;
   logic [N-1:0]   req_rot;
   int             start;
   int             offset;
   int             sum;

   always_comb begin
      // Search origin wraps to 0 when the last grant was the top source.
      start = int'(last_grant_i) + 1;
      if (start >= N) start = 0;

      // Rotating a doubled copy avoids a variable-width wrap.
      req_dbl   = {req_i, req_i};
      req_shift = req_dbl >> start;
      req_rot   = req_shift[N-1:0];

      offset = 0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_rot[i]) offset = i;
      end

      found_o = |req_rot;
      sum     = start + offset;
      if (sum >= N) sum = sum - N;
      grant_o = sum[W-1:0];
   end

endmodule

// File: rtl/new_task_arbiter.sv
// -----------------------------------------------------------------------------
// new_task_arbiter
// Merges the per-accelerator new-task streams into one AXI-Stream that feeds
// the cutoff manager. A source is chosen round-robin, holds the grant until its
// tlast beat is accepted, and every beat is tagged with the source index on tid.
// The output is a single registered stage that supports load and drain in the
// same cycle, so a locked packet streams at one beat per cycle.
//
// Valid/ready: a beat moves on any edge where tvalid and tready are both 1;
// tvalid never drops and data never changes until that happens.
//
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   acc_tvalid/tready  : per-source handshake (NUM_ACCS bits)
//   acc_tdata          : per-source data, source g at [64g+63:64g]
//   acc_tlast          : per-source end of packet
//   acc_tdest          : per-source destination, source g at [5g+4:5g]
//   inStream_*         : merged output stream; tid carries the grant index,
//                        tdest is taken from the first beat of the packet
// -----------------------------------------------------------------------------
module new_task_arbiter #(
   parameter int NUM_ACCS = 16,
   parameter int ACC_BITS = OmpSsManager::ACC_BITS
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_ACCS-1:0]     acc_tvalid,
   output logic [NUM_ACCS-1:0]     acc_tready,
   input  logic [64*NUM_ACCS-1:0]  acc_tdata,
   input  logic [NUM_ACCS-1:0]     acc_tlast,
   input  logic [5*NUM_ACCS-1:0]   acc_tdest,
   output logic                    inStream_tvalid,
   input  logic                    inStream_tready,
   output logic [63:0]             inStream_tdata,
   output logic                    inStream_tlast,
   output logic [3:0]              inStream_tid,
   output logic [4:0]              inStream_tdest
);

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [ACC_BITS-1:0]  grant_q, grant_d;
   logic [ACC_BITS-1:0]  last_grant_q, last_grant_d;
   logic                 first_q, first_d;
   logic                 out_full_q, out_full_d;
   logic [63:0]          data_q, data_d;
   logic                 last_q, last_d;
   logic [ACC_BITS-1:0]  tid_q, tid_d;
   logic [4:0]           dest_q, dest_d;

   logic                 found;
   logic [ACC_BITS-1:0]  pick;
   logic                 ready_en;
   logic                 accept;
   logic                 sel_valid;
   logic                 sel_last;
   logic [63:0]          sel_data;
   logic [4:0]           sel_dest;

   rr_picker #(
      .N (NUM_ACCS),
      .W (ACC_BITS)
   ) u_rr_picker (
      .req_i        (acc_tvalid),
      .last_grant_i (last_grant_q),
      .found_o      (found),
      .grant_o      (pick)
   );

   // Source mux driven by the held grant.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      sel_dest  = '0;
      for (int g = 0; g < NUM_ACCS; g++) begin
         if (grant_q == ACC_BITS'(g)) begin
            sel_valid = acc_tvalid[g];
            sel_last  = acc_tlast[g];
            sel_data  = acc_tdata[64*g +: 64];
            sel_dest  = acc_tdest[5*g +: 5];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      first_d      = first_q;
      out_full_d   = out_full_q;
      data_d       = data_q;
      last_d       = last_q;
      tid_d        = tid_q;
      dest_d       = dest_q;
      ready_en     = 1'b0;
      acc_tready   = '0;
      accept       = 1'b0;

      // Drain first; a load below overrides it so load+drain keeps full set.
      if (out_full_q && inStream_tready) out_full_d = 1'b0;

      case (state_q)
         ARB: begin
            if (found) begin
               grant_d = pick;
               first_d = 1'b1;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            ready_en = !out_full_q || inStream_tready;
            if (ready_en) acc_tready = NUM_ACCS'(1) << grant_q;
            accept = ready_en && sel_valid;
            if (accept) begin
               out_full_d = 1'b1;
               data_d     = sel_data;
               last_d     = sel_last;
               tid_d      = grant_q;
               first_d    = 1'b0;
               // tdest is only meaningful on the first beat of a packet.
               if (first_q) dest_d = sel_dest;
               if (sel_last) begin
                  last_grant_d = grant_q;
                  state_d      = ARB;
               end
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ARB;
         grant_q      <= '0;
         last_grant_q <= ACC_BITS'(NUM_ACCS - 1);
         first_q      <= 1'b0;
         out_full_q   <= 1'b0;
         data_q       <= '0;
         last_q       <= 1'b0;
         tid_q        <= '0;
         dest_q       <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         first_q      <= first_d;
         out_full_q   <= out_full_d;
         data_q       <= data_d;
         last_q       <= last_d;
         tid_q        <= tid_d;
         dest_q       <= dest_d;
      end
   end

   assign inStream_tvalid = out_full_q;
   assign inStream_tdata  = data_q;
   assign inStream_tlast  = last_q;
   assign inStream_tid    = 4'(tid_q);
   assign inStream_tdest  = dest_q;

endmodule

// File: tb/tb_new_task_arbiter.sv
// -----------------------------------------------------------------------------
// tb_new_task_arbiter
// Directed bench for new_task_arbiter (NUM_ACCS = 16). Each source has a queue
// of beats that a source engine presents one at a time; a beat may carry a
// number of idle cycles to insert before it is offered. The merged stream is
// compared beat by beat against a hand-ordered expected queue.
// -----------------------------------------------------------------------------
module tb_new_task_arbiter;

   localparam int N = 16;

   typedef struct {
      logic [63:0] data;
      logic        last;
      logic [4:0]  dest;
      int          gap;
   } beat_t;

   // ---------------------------------------------------------------- clock/reset
   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    acc_tvalid;
   logic [N-1:0]    acc_tready;
   logic [64*N-1:0] acc_tdata;
   logic [N-1:0]    acc_tlast;
   logic [5*N-1:0]  acc_tdest;
   logic            inStream_tvalid;
   logic            inStream_tready;
   logic [63:0]     inStream_tdata;
   logic            inStream_tlast;
   logic [3:0]      inStream_tid;
   logic [4:0]      inStream_tdest;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   new_task_arbiter #(
      .NUM_ACCS (N)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .acc_tvalid      (acc_tvalid),
      .acc_tready      (acc_tready),
      .acc_tdata       (acc_tdata),
      .acc_tlast       (acc_tlast),
      .acc_tdest       (acc_tdest),
      .inStream_tvalid (inStream_tvalid),
      .inStream_tready (inStream_tready),
      .inStream_tdata  (inStream_tdata),
      .inStream_tlast  (inStream_tlast),
      .inStream_tid    (inStream_tid),
      .inStream_tdest  (inStream_tdest)
   );

   // ---------------------------------------------------------------- scoreboard
   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [79:0] exp_q[$];

   task automatic check(input string tag, input logic [79:0] observed,
                        input logic [79:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic exp_beat(input logic [3:0] tid, input logic [4:0] dest,
                           input logic last, input logic [63:0] data);
      exp_q.push_back(80'({tid, dest, last, data}));
   endtask

   // ---------------------------------------------------------------- drivers
   beat_t        src_q[N][$];
   int           gap_cnt[N];
   logic [N-1:0] armed;
   logic [N-1:0] acc_hs;

   task automatic push_beat(input int s, input logic [63:0] data, input logic last,
                            input logic [4:0] dest, input int gap);
      beat_t b;
      b.data = data;
      b.last = last;
      b.dest = dest;
      b.gap  = gap;
      src_q[s].push_back(b);
   endtask

   task automatic drive_sources();
      for (int s = 0; s < N; s++) begin
         if (rst) begin
            src_q[s].delete();
            armed[s]   = 1'b0;
            gap_cnt[s] = 0;
         end else if (acc_hs[s] && src_q[s].size() > 0) begin
            src_q[s].delete(0);
            armed[s] = 1'b0;
         end
         acc_tvalid[s]          = 1'b0;
         acc_tlast[s]           = 1'b0;
         acc_tdata[64*s +: 64]  = '0;
         acc_tdest[5*s +: 5]    = '0;
         if (src_q[s].size() > 0) begin
            if (!armed[s]) begin
               armed[s]   = 1'b1;
               gap_cnt[s] = src_q[s][0].gap;
            end
            if (gap_cnt[s] > 0) begin
               gap_cnt[s]--;
            end else begin
               acc_tvalid[s]         = 1'b1;
               acc_tlast[s]          = src_q[s][0].last;
               acc_tdata[64*s +: 64] = src_q[s][0].data;
               acc_tdest[5*s +: 5]   = src_q[s][0].dest;
            end
         end
      end
   endtask

   // Source engine and output monitor: sample at negedge, update after posedge.
   initial begin
      acc_tvalid = '0;
      acc_tlast  = '0;
      acc_tdata  = '0;
      acc_tdest  = '0;
      armed      = '0;
      acc_hs     = '0;
      for (int s = 0; s < N; s++) gap_cnt[s] = 0;
      forever begin
         @(negedge clk);
         acc_hs = acc_tvalid & acc_tready;
         if (rst === 1'b0) begin
            check("tready_onehot0", 80'($onehot0(acc_tready)), 80'(1));
            if (inStream_tvalid && inStream_tready) begin
               check("beat_expected", 80'(exp_q.size() > 0), 80'(1));
               if (exp_q.size() > 0)
                  check("beat", 80'({inStream_tid, inStream_tdest, inStream_tlast,
                                     inStream_tdata}), exp_q.pop_front());
            end
         end
         @(posedge clk);
         #1;
         drive_sources();
      end
   end

   task automatic apply_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < 200) begin
         @(negedge clk);
         i++;
      end
      repeat (4) @(negedge clk);
      check(tag, 80'(exp_q.size()), 80'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d tests run", tests_run);
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- tests
   int t_v, t_o, n, bad;

   initial begin
      rst             = 1'b1;
      inStream_tready = 1'b1;
      repeat (3) @(posedge clk);

      // Reset state
      @(negedge clk);
      check("rst_tvalid", 80'(inStream_tvalid), 80'(0));
      check("rst_tready", 80'(acc_tready), 80'(0));
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      check("idle_tvalid", 80'(inStream_tvalid), 80'(0));
      check("idle_tdata", 80'(inStream_tdata), 80'(0));
      check("idle_tlast", 80'(inStream_tlast), 80'(0));
      check("idle_tid", 80'(inStream_tid), 80'(0));
      check("idle_tdest", 80'(inStream_tdest), 80'(0));

      // Source 2, three beats; later beats carry different tdest to show latching
      @(posedge clk);
      #2;
      push_beat(2, 64'h11, 1'b0, 5'h1F, 0);
      push_beat(2, 64'h22, 1'b0, 5'h03, 0);
      push_beat(2, 64'h33, 1'b1, 5'h07, 0);
      exp_beat(4'd2, 5'h1F, 1'b0, 64'h11);
      exp_beat(4'd2, 5'h1F, 1'b0, 64'h22);
      exp_beat(4'd2, 5'h1F, 1'b1, 64'h33);
      t_v = -1;
      t_o = -1;
      for (int i = 0; i < 20 && t_o < 0; i++) begin
         @(negedge clk);
         if (t_v < 0 && acc_tvalid[2]) t_v = cyc;
         if (inStream_tvalid) t_o = cyc;
      end
      check("t1_latency", 80'(t_o - t_v), 80'(2));
      n = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!inStream_tvalid) break;
         n++;
      end
      check("t1_burst_len", 80'(n), 80'(3));
      wait_drain("t1_drain");

      // Sources 0, 1, 3 contend after reset; source 0 re-requests
      apply_reset();
      push_beat(0, 64'hA0, 1'b1, 5'h01, 0);
      push_beat(0, 64'hA1, 1'b1, 5'h02, 0);
      push_beat(1, 64'hB1, 1'b1, 5'h03, 0);
      push_beat(3, 64'hC3, 1'b1, 5'h04, 0);
      exp_beat(4'd0, 5'h01, 1'b1, 64'hA0);
      exp_beat(4'd1, 5'h03, 1'b1, 64'hB1);
      exp_beat(4'd3, 5'h04, 1'b1, 64'hC3);
      exp_beat(4'd0, 5'h02, 1'b1, 64'hA1);
      wait_drain("t2_drain");

      // Output backpressure for 5 cycles in the middle of a packet from source 6
      @(posedge clk);
      #2;
      push_beat(6, 64'h61, 1'b0, 5'h06, 0);
      push_beat(6, 64'h62, 1'b0, 5'h06, 0);
      push_beat(6, 64'h63, 1'b0, 5'h06, 0);
      push_beat(6, 64'h64, 1'b1, 5'h06, 0);
      exp_beat(4'd6, 5'h06, 1'b0, 64'h61);
      exp_beat(4'd6, 5'h06, 1'b0, 64'h62);
      exp_beat(4'd6, 5'h06, 1'b0, 64'h63);
      exp_beat(4'd6, 5'h06, 1'b1, 64'h64);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (inStream_tvalid) break;
      end
      @(posedge clk);
      #2 inStream_tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t3_hold_data", 80'(inStream_tdata), 80'(64'h62));
         check("t3_hold_valid", 80'(inStream_tvalid), 80'(1));
         check("t3_src_ready", 80'(acc_tready[6]), 80'(0));
      end
      @(posedge clk);
      #2 inStream_tready = 1'b1;
      wait_drain("t3_drain");

      // Locked source 4 idles 3 cycles mid-packet while source 5 waits
      @(posedge clk);
      #2;
      push_beat(4, 64'h41, 1'b0, 5'h14, 0);
      push_beat(4, 64'h42, 1'b0, 5'h14, 3);
      push_beat(4, 64'h43, 1'b1, 5'h14, 0);
      push_beat(5, 64'h51, 1'b1, 5'h15, 0);
      exp_beat(4'd4, 5'h14, 1'b0, 64'h41);
      exp_beat(4'd4, 5'h14, 1'b0, 64'h42);
      exp_beat(4'd4, 5'h14, 1'b1, 64'h43);
      exp_beat(4'd5, 5'h15, 1'b1, 64'h51);
      bad = 0;
      for (int i = 0; i < 40 && src_q[4].size() > 0; i++) begin
         @(negedge clk);
         if (acc_tready[5]) bad++;
      end
      check("t4_src5_ready_while_locked", 80'(bad), 80'(0));
      check("t4_src4_done", 80'(src_q[4].size()), 80'(0));
      wait_drain("t4_drain");

      // Wrap-around: after a grant to 15, source 0 wins over 15
      @(posedge clk);
      #2;
      push_beat(15, 64'hF1, 1'b1, 5'h0F, 0);
      exp_beat(4'd15, 5'h0F, 1'b1, 64'hF1);
      wait_drain("t5_prime_drain");
      @(posedge clk);
      #2;
      push_beat(15, 64'hF2, 1'b1, 5'h0E, 0);
      push_beat(0, 64'h01, 1'b1, 5'h10, 0);
      exp_beat(4'd0, 5'h10, 1'b1, 64'h01);
      exp_beat(4'd15, 5'h0E, 1'b1, 64'hF2);
      wait_drain("t5_drain");

      // Reset during beat 2 of a 4-beat packet from source 7
      @(posedge clk);
      #2;
      push_beat(7, 64'h71, 1'b0, 5'h07, 0);
      push_beat(7, 64'h72, 1'b0, 5'h07, 0);
      push_beat(7, 64'h73, 1'b0, 5'h07, 0);
      push_beat(7, 64'h74, 1'b1, 5'h07, 0);
      exp_beat(4'd7, 5'h07, 1'b0, 64'h71);
      exp_beat(4'd7, 5'h07, 1'b0, 64'h72);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (inStream_tvalid && inStream_tdata == 64'h72) break;
      end
      #1 rst = 1'b1;
      #1;
      check("t6_rst_tvalid", 80'(inStream_tvalid), 80'(0));
      check("t6_rst_tdata", 80'(inStream_tdata), 80'(0));
      check("t6_rst_tid", 80'(inStream_tid), 80'(0));
      check("t6_rst_tdest", 80'(inStream_tdest), 80'(0));
      check("t6_rst_tready", 80'(acc_tready), 80'(0));
      check("t6_beats_before_rst", 80'(exp_q.size()), 80'(0));
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      push_beat(9, 64'h91, 1'b1, 5'h09, 0);
      push_beat(0, 64'h02, 1'b1, 5'h00, 0);
      exp_beat(4'd0, 5'h00, 1'b1, 64'h02);
      exp_beat(4'd9, 5'h09, 1'b1, 64'h91);
      wait_drain("t6_drain");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
